// File: rtl/cpu_run_sequencer.sv
// Run-control sequencer for the 8-bit two-stage CPU: owns the PC and the IF/ID
// register, gates the register-file write and counts retired instructions.
module cpu_run_sequencer #(
    parameter int                     PC_WIDTH    = 4,
    parameter int                     INSTR_WIDTH = 8,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = 8'hFF,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   step,
    input  logic                   halt_req,
    input  logic                   bp_en,
    input  logic [PC_WIDTH-1:0]    bp_addr,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic                   ifid_valid,
    output logic                   reg_write_en,
    output logic                   busy,
    output logic                   paused,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   retired_count,
    output logic [2:0]             state_dbg
);

    // Control pulses: start and step are single-cycle strobes sampled on the
    // rising edge; they are only acted on in the states that accept them and
    // are silently dropped elsewhere. halt_req is a level, sampled only in RUN.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        PAUSED = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic REASON_PAUSE = 1'b0;
    localparam logic REASON_DONE  = 1'b1;

    state_t state, state_next;
    logic   reason, reason_next;
    logic   skip_bp, skip_bp_next;
    logic   fetch;
    logic   restart;
    logic   is_halt;
    logic   bp_hit;

    assign is_halt = (instr_in == HALT_OPCODE);
    assign bp_hit  = bp_en && (pc == bp_addr) && !skip_bp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            reason  <= REASON_PAUSE;
            skip_bp <= 1'b0;
        end else begin
            state   <= state_next;
            reason  <= reason_next;
            skip_bp <= skip_bp_next;
        end
    end

    always_comb begin
        state_next   = state;
        reason_next  = reason;
        skip_bp_next = skip_bp;
        fetch        = 1'b0;
        restart      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    restart      = 1'b1;
                    skip_bp_next = 1'b0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (is_halt) begin
                    reason_next = REASON_DONE;
                    state_next  = DRAIN;
                end else if (bp_hit) begin
                    reason_next = REASON_PAUSE;
                    state_next  = DRAIN;
                end else if (halt_req) begin
                    reason_next = REASON_PAUSE;
                    state_next  = DRAIN;
                end else begin
                    fetch        = 1'b1;
                    skip_bp_next = 1'b0;
                end
            end
            STEP: begin
                // A single step ignores breakpoint and halt_req, but never
                // executes the HALT opcode.
                if (is_halt) begin
                    reason_next = REASON_DONE;
                end else begin
                    fetch        = 1'b1;
                    skip_bp_next = 1'b0;
                    reason_next  = REASON_PAUSE;
                end
                state_next = DRAIN;
            end
            DRAIN: begin
                state_next = (reason == REASON_DONE) ? DONE : PAUSED;
            end
            PAUSED: begin
                if (start) begin
                    skip_bp_next = 1'b1;
                    state_next   = RUN;
                end else if (step) begin
                    state_next = STEP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The IF/ID slot is valid only on the cycle after a fetch, so every
    // non-fetching edge retires the pending instruction and empties the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            ifid_instr <= '0;
            ifid_valid <= 1'b0;
        end else begin
            ifid_valid <= fetch;
            if (restart) begin
                pc <= '0;
            end else if (fetch) begin
                pc         <= pc + PC_WIDTH'(1);
                ifid_instr <= instr_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= '0;
        end else if (restart) begin
            retired_count <= '0;
        end else if (ifid_valid && (retired_count != {CNT_WIDTH{1'b1}})) begin
            retired_count <= retired_count + CNT_WIDTH'(1);
        end
    end

    assign reg_write_en = ifid_valid;
    assign busy         = (state == RUN) || (state == STEP) || (state == DRAIN);
    assign paused       = (state == PAUSED);
    assign done         = (state == DONE);
    assign state_dbg    = state;

    valid_only_in_run_or_drain: assert property (
        @(posedge clk) disable iff (rst)
        ifid_valid |-> (state == RUN || state == DRAIN)
    );

    halt_never_in_ifid: assert property (
        @(posedge clk) disable iff (rst)
        ifid_valid |-> (ifid_instr != HALT_OPCODE)
    );

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: small instruction memory model, IF/ID
// stream scoreboard and hand-computed expectations per scenario.
module tb_cpu_run_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step;
    logic        halt_req;
    logic        bp_en;
    logic [3:0]  bp_addr;
    logic [7:0]  instr_in;
    logic [3:0]  pc;
    logic [7:0]  ifid_instr;
    logic        ifid_valid;
    logic        reg_write_en;
    logic        busy;
    logic        paused;
    logic        done;
    logic [15:0] retired_count;
    logic [2:0]  state_dbg;

    logic [7:0]  mem [16];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          vec_cnt;
    int          err_cnt;
    int          we_cycles;

    cpu_run_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .step          (step),
        .halt_req      (halt_req),
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
        .instr_in      (instr_in),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .reg_write_en  (reg_write_en),
        .busy          (busy),
        .paused        (paused),
        .done          (done),
        .retired_count (retired_count),
        .state_dbg     (state_dbg)
    );

    assign instr_in = mem[pc];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic load_prog(input logic [7:0] fill, input int n, input logic [7:0] p0,
                             input logic [7:0] p1, input logic [7:0] p2,
                             input logic [7:0] p3, input logic [7:0] p4);
        for (int i = 0; i < 16; i++) mem[i] = fill;
        if (n > 0) mem[0] = p0;
        if (n > 1) mem[1] = p1;
        if (n > 2) mem[2] = p2;
        if (n > 3) mem[3] = p3;
        if (n > 4) mem[4] = p4;
    endtask

    // Runs until PAUSED or DONE, logging each IF/ID write cycle.
    task automatic run_until_stop(input string tag);
        int n;
        n = 0;
        we_cycles = 0;
        while (!(paused || done) && n < 64) begin
            @(negedge clk);
            if (reg_write_en) begin
                we_cycles++;
                got_q.push_back(ifid_instr);
            end
            n++;
        end
        check_eq({tag, "_timeout"}, (paused || done) ? 32'd0 : 32'd1, 32'd0);
    endtask

    // scoreboard
    task automatic compare_stream(input string tag);
        int n;
        check_eq({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_ifid%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        start    = 1'b0;
        step     = 1'b0;
        halt_req = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = 4'd0;
        load_prog(8'h00, 5, 8'h08, 8'h19, 8'h2A, 8'h3B, 8'hFF);
        apply_reset();

        // reset state
        check_eq("rst_pc", pc, 0);
        check_eq("rst_ifid_instr", ifid_instr, 0);
        check_eq("rst_ifid_valid", ifid_valid, 0);
        check_eq("rst_retired", retired_count, 0);
        check_eq("rst_flags", {busy, paused, done}, 3'b000);
        check_eq("rst_state", state_dbg, 3'd0);

        // plain run to HALT opcode
        pulse_start();
        check_eq("t1_busy", busy, 1);
        run_until_stop("t1");
        exp_q = '{8'h08, 8'h19, 8'h2A, 8'h3B};
        compare_stream("t1");
        check_eq("t1_we_cycles", we_cycles, 4);
        check_eq("t1_pc", pc, 4);
        check_eq("t1_retired", retired_count, 4);
        check_eq("t1_flags", {busy, paused, done}, 3'b001);
        check_eq("t1_ifid_hold", ifid_instr, 8'h3B);

        // breakpoint at 2, then resume past it
        bp_en   = 1'b1;
        bp_addr = 4'd2;
        pulse_start();
        run_until_stop("t2a");
        exp_q = '{8'h08, 8'h19};
        compare_stream("t2a");
        check_eq("t2a_flags", {busy, paused, done}, 3'b010);
        check_eq("t2a_pc", pc, 2);
        check_eq("t2a_retired", retired_count, 2);
        pulse_start();
        run_until_stop("t2b");
        exp_q = '{8'h2A, 8'h3B};
        compare_stream("t2b");
        check_eq("t2b_done", done, 1);
        check_eq("t2b_retired", retired_count, 4);

        // breakpoint at 0, then two single steps
        bp_addr = 4'd0;
        pulse_start();
        run_until_stop("t3a");
        check_eq("t3a_paused", paused, 1);
        check_eq("t3a_pc", pc, 0);
        check_eq("t3a_retired", retired_count, 0);
        got_q.delete();
        for (int s = 0; s < 2; s++) begin
            pulse_step();
            run_until_stop($sformatf("t3_step%0d", s));
            check_eq($sformatf("t3_step%0d_we", s), we_cycles, 1);
            check_eq($sformatf("t3_step%0d_paused", s), paused, 1);
        end
        exp_q = '{8'h08, 8'h19};
        compare_stream("t3");
        check_eq("t3_pc", pc, 2);
        check_eq("t3_retired", retired_count, 2);
        check_eq("t3_valid", ifid_valid, 0);

        // one-cycle halt_req at pc=1
        bp_en = 1'b0;
        apply_reset();
        pulse_start();
        @(negedge clk);
        check_eq("t4a_pc_before", pc, 1);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        run_until_stop("t4a");
        check_eq("t4a_flags", {busy, paused, done}, 3'b010);
        check_eq("t4a_pc", pc, 1);
        check_eq("t4a_retired", retired_count, 1);
        got_q.delete();

        // halt_req and HALT opcode in the same cycle: HALT wins
        load_prog(8'h00, 2, 8'h08, 8'hFF, 8'h00, 8'h00, 8'h00);
        apply_reset();
        pulse_start();
        @(negedge clk);
        check_eq("t4b_instr_is_halt", instr_in, 8'hFF);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        run_until_stop("t4b");
        check_eq("t4b_flags", {busy, paused, done}, 3'b001);
        check_eq("t4b_pc", pc, 1);
        check_eq("t4b_retired", retired_count, 1);
        got_q.delete();

        // PC wrap with a memory full of 08
        load_prog(8'h08, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply_reset();
        pulse_start();
        repeat (16) @(negedge clk);
        check_eq("t5_wrap_pc", pc, 0);
        check_eq("t5_wrap_retired", retired_count, 15);
        check_eq("t5_wrap_busy", busy, 1);
        repeat (2) @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        run_until_stop("t5");
        check_eq("t5_paused", paused, 1);
        check_eq("t5_pc", pc, 2);
        check_eq("t5_retired", retired_count, 18);
        got_q.delete();

        // asynchronous reset mid-RUN
        pulse_start();
        repeat (3) @(negedge clk);
        check_eq("t6_running", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_pc", pc, 0);
        check_eq("t6_async_valid", ifid_valid, 0);
        check_eq("t6_async_instr", ifid_instr, 0);
        check_eq("t6_async_retired", retired_count, 0);
        check_eq("t6_async_flags", {busy, paused, done}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        check_eq("t6_restart_pc", pc, 0);
        repeat (3) @(negedge clk);
        check_eq("t6_after_pc", pc, 3);
        check_eq("t6_after_retired", retired_count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
- Run-control sequencer for the 8-bit two-stage CPU (fetch into an IF/ID register, then decode/ALU/register-file write).
- Owns the PC and the IF/ID register, and gates the register-file write.
- Provides start, single-step, halt-request, breakpoint and HALT-opcode termination.
- Counts retired instructions for the bench and the debug host.

Parameters:
- PC_WIDTH, 4, width of the PC; instruction memory depth is 2^PC_WIDTH.
- INSTR_WIDTH, 8, instruction width.
- HALT_OPCODE, 8'hFF, instruction value that ends the program; it is never executed.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin from IDLE/DONE, or resume from PAUSED.
- step  in  1  one-cycle pulse: execute exactly one instruction from PAUSED.
- halt_req  in  1  level: pause at the next fetch opportunity.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  PC_WIDTH  breakpoint PC.
- instr_in  in  INSTR_WIDTH  instruction memory data at pc (combinational read).
- pc  out  PC_WIDTH  fetch address.
- ifid_instr  out  INSTR_WIDTH  IF/ID register, drives the decode/control logic.
- ifid_valid  out  1  IF/ID holds a real instruction.
- reg_write_en  out  1  register-file write gate; equals ifid_valid.
- busy  out  1  state is RUN, STEP or DRAIN.
- paused  out  1  state is PAUSED.
- done  out  1  state is DONE.
- retired_count  out  CNT_WIDTH  instructions executed since the last start from IDLE/DONE.

Behaviour:
- Reset (async, any state): state IDLE; pc=0, ifid_instr=0, ifid_valid=0, retired_count=0, skip_bp=0; busy, paused and done are all 0.
- States: IDLE, RUN, STEP, DRAIN, PAUSED, DONE. A 1-bit reason register selects the DRAIN exit (PAUSED or DONE).
- Retire rule: on every clk edge where ifid_valid=1, retired_count increments. It saturates at all-ones.
- Fetch: ifid_instr<=instr_in, ifid_valid<=1, pc<=pc+1. The PC wraps from 2^PC_WIDTH-1 to 0 silently and execution continues.
- IDLE / DONE, on start:
  - clear retired_count and pc, set skip_bp=0, go to RUN.
  - The first fetch happens on the edge after RUN is entered.
- RUN, each edge, checks evaluated in this priority order:
  1. instr_in==HALT_OPCODE: no fetch, pc holds, reason=DONE, go to DRAIN.
  2. bp_en and pc==bp_addr and !skip_bp: no fetch, reason=PAUSE, go to DRAIN.
  3. halt_req: no fetch, reason=PAUSE, go to DRAIN.
  4. Otherwise: fetch and clear skip_bp.
- DRAIN, one cycle:
  - The pending IF/ID instruction (if valid) executes and retires.
  - ifid_valid<=0, then go to PAUSED or DONE per the reason register.
- PAUSED:
  - start: set skip_bp=1, go to RUN. The breakpoint at the current pc is ignored for exactly one fetch.
  - step (with no start): go to STEP.
  - If start and step arrive together, start wins.
- STEP, one cycle:
  - If instr_in==HALT_OPCODE: reason=DONE, no fetch.
  - Otherwise: fetch with breakpoint and halt_req ignored, reason=PAUSE.
  - Then go to DRAIN, so a step is exactly one retire.
- Ignored inputs:
  - start in RUN, STEP or DRAIN.
  - step in any state other than PAUSED.
  - halt_req outside RUN.
- Registered outputs: pc, ifid_instr and ifid_valid. busy, paused and done decode directly from state.
- ifid_instr retains its last value when ifid_valid=0.

Test Plan:
- Memory 08,19,2A,3B,FF; pulse start → IF/ID sees 08,19,2A,3B on consecutive edges; reg_write_en high for 4 cycles; DRAIN, then DONE with pc=4, retired_count=4, done=1; FF never appears in IF/ID.
- Same memory, bp_en=1, bp_addr=2, start → PAUSED with pc=2, retired_count=2; then pulse start → fetches 2A,3B, then DONE with retired_count=4.
- bp_addr=0, bp_en=1, start → PAUSED with pc=0 and retired_count=0; two step pulses, each followed by return to PAUSED → pc=2, retired_count=2, exactly one reg_write_en cycle per step.
- halt_req asserted for 1 cycle while pc=1 in RUN → PAUSED with pc=1, retired_count=1; halt_req and the HALT opcode seen in the same cycle → DONE, not PAUSED.
- All 16 memory entries 08 → after 16 fetches pc wraps to 0 and execution continues; halt_req then pauses with retired_count=N exactly.
- rst asserted asynchronously mid-RUN (between edges) → all outputs clear immediately; the next start runs from pc=0 with retired_count=0.
